// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared frame-buffer geometry and plotter FSM state encoding
package vga_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAW,
        ST_DONE
    } state_t;
endpackage

// File: rtl/xy_scan_counter.sv
// rtl/xy_scan_counter.sv - raster x/y counter over a latched origin/extent window
module xy_scan_counter
    import vga_pkg::*;
(
    input  logic           clock,
    input  logic           resetn,
    input  logic           load,
    input  logic           enable,
    input  logic [X_W-1:0] x_org,
    input  logic [Y_W-1:0] y_org,
    input  logic [X_W-1:0] x_end,
    input  logic [Y_W-1:0] y_end,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);
    logic [X_W-1:0] x_q, x_d, x_org_q, x_end_q;
    logic [Y_W-1:0] y_q, y_d, y_org_q, y_end_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q     <= '0;
            y_q     <= '0;
            x_org_q <= '0;
            y_org_q <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (load) begin
                x_org_q <= x_org;
                y_org_q <= y_org;
                x_end_q <= x_end;
                y_end_q <= y_end;
            end
        end
    end

    // The latched origin is kept so each row wraps back to the left edge of the box.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            x_d = x_org;
            y_d = y_org;
        end else if (enable) begin
            if (x_q == x_end_q) begin
                x_d = x_org_q;
                y_d = (y_q == y_end_q) ? y_org_q : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == x_end_q) && (y_q == y_end_q);
endmodule

// File: rtl/rect_fill_plotter.sv
// rtl/rect_fill_plotter.sv - clipped rectangle / full-screen fill pixel generator
module rect_fill_plotter #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H,
    parameter int COLOUR_W = vga_pkg::COLOUR_W
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        clear,
    input  logic [vga_pkg::X_W-1:0]     x0,
    input  logic [vga_pkg::Y_W-1:0]     y0,
    input  logic [vga_pkg::X_W-1:0]     w,
    input  logic [vga_pkg::Y_W-1:0]     h,
    input  logic [COLOUR_W-1:0]         colour_in,
    output logic [vga_pkg::X_W-1:0]     x,
    output logic [vga_pkg::Y_W-1:0]     y,
    output logic [COLOUR_W-1:0]         colour,
    output logic                        plot,
    output logic                        busy,
    output logic                        done
);
    localparam int XW = vga_pkg::X_W;
    localparam int YW = vga_pkg::Y_W;
    localparam logic [XW:0]   SW_LIM = (XW+1)'(SCREEN_W);
    localparam logic [YW:0]   SH_LIM = (YW+1)'(SCREEN_H);
    localparam logic [XW-1:0] X_MAX  = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(SCREEN_H - 1);

    vga_pkg::state_t state_q, state_d;

    logic                clear_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [XW:0]         x_sum;
    logic [YW:0]         y_sum;
    logic [XW-1:0]       org_x, end_x, cnt_x, x_q;
    logic [YW-1:0]       org_y, end_y, cnt_y, y_q;
    logic                degenerate;
    logic                cnt_load, cnt_en, cnt_last;
    logic [COLOUR_W-1:0] colour_out_q;
    logic                plot_q, busy_q, done_q;

    // Sums are one bit wider than the coordinates so the clip compare never sees a wrap.
    always_comb begin
        x_sum = {1'b0, x0} + {1'b0, w};
        y_sum = {1'b0, y0} + {1'b0, h};
        if (clear_q) begin
            org_x = '0;
            org_y = '0;
            end_x = X_MAX;
            end_y = Y_MAX;
        end else begin
            org_x = x0;
            org_y = y0;
            end_x = (x_sum > SW_LIM) ? X_MAX : x_sum[XW-1:0] - 1'b1;
            end_y = (y_sum > SH_LIM) ? Y_MAX : y_sum[YW-1:0] - 1'b1;
        end
        degenerate = !clear_q && ((w == '0) || (h == '0) ||
                     ({1'b0, x0} >= SW_LIM) || ({1'b0, y0} >= SH_LIM));
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            vga_pkg::ST_IDLE: if (start) state_d = vga_pkg::ST_LOAD;
            vga_pkg::ST_LOAD: begin
                cnt_load = 1'b1;
                state_d  = degenerate ? vga_pkg::ST_DONE : vga_pkg::ST_DRAW;
            end
            vga_pkg::ST_DRAW: begin
                cnt_en = 1'b1;
                if (cnt_last) state_d = vga_pkg::ST_DONE;
            end
            vga_pkg::ST_DONE: state_d = vga_pkg::ST_IDLE;
            default:          state_d = vga_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= vga_pkg::ST_IDLE;
            clear_q      <= 1'b0;
            colour_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_out_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == vga_pkg::ST_IDLE && start) clear_q  <= clear;
            if (state_q == vga_pkg::ST_LOAD)          colour_q <= colour_in;
            // Pixel, colour and strobe leave through one register stage together.
            if (state_q == vga_pkg::ST_DRAW) begin
                x_q          <= cnt_x;
                y_q          <= cnt_y;
                colour_out_q <= colour_q;
            end
            plot_q <= (state_q == vga_pkg::ST_DRAW);
            busy_q <= (state_d == vga_pkg::ST_LOAD) || (state_d == vga_pkg::ST_DRAW);
            done_q <= (state_q == vga_pkg::ST_DONE);
        end
    end

    xy_scan_counter u_scan (
        .clock  (clock),
        .resetn (resetn),
        .load   (cnt_load),
        .enable (cnt_en),
        .x_org  (org_x),
        .y_org  (org_y),
        .x_end  (end_x),
        .y_end  (end_y),
        .x      (cnt_x),
        .y      (cnt_y),
        .last   (cnt_last)
    );

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_out_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_rect_fill_plotter.sv
// tb/tb_rect_fill_plotter.sv - self-checking bench for rect_fill_plotter
module tb_rect_fill_plotter;
    localparam int W = 160;
    localparam int H = 120;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [7:0] w = '0;
    logic [6:0] h = '0;
    logic [2:0] colour_in = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    rect_fill_plotter #(.SCREEN_W(W), .SCREEN_H(H), .COLOUR_W(3)) dut (
        .clock(clock), .resetn(resetn), .start(start), .clear(clear),
        .x0(x0), .y0(y0), .w(w), .h(h), .colour_in(colour_in),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    typedef struct {
        logic clr;
        int   vx0, vy0, vw, vh, vcol;
        int   n, fx, fy, lx, ly;
    } vec_t;

    pix_t got_q[$];
    pix_t exp_q[$];
    int   cyc = 0;
    int   first_cyc, last_cyc, done_cyc, done_cnt;
    int   total = 0;
    int   bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (resetn) begin
            if (plot) begin
                got_q.push_back(pix_t'{x, y, colour});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Reference: every pixel of the clipped box, row by row.
    task automatic model(input logic clr, input int ax0, ay0, aw, ah, acol);
        int xs, ys, xe, ye;
        exp_q.delete();
        if (clr) begin
            xs = 0; ys = 0; xe = W - 1; ye = H - 1;
        end else if (aw == 0 || ah == 0 || ax0 >= W || ay0 >= H) begin
            return;
        end else begin
            xs = ax0; ys = ay0;
            xe = ((ax0 + aw < W) ? ax0 + aw : W) - 1;
            ye = ((ay0 + ah < H) ? ay0 + ah : H) - 1;
        end
        for (int yy = ys; yy <= ye; yy++)
            for (int xx = xs; xx <= xe; xx++)
                exp_q.push_back(pix_t'{8'(xx), 7'(yy), 3'(acol)});
    endtask

    task automatic run_req(input string nm, input logic clr, input int ax0, ay0, aw, ah,
                           input int acol, input bit poke);
        int  n0, mism, nchk;
        bit  seen;
        model(clr, ax0, ay0, aw, ah, acol);
        @(negedge clock); #1;
        got_q.delete();
        first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
        clear = clr; x0 = 8'(ax0); y0 = 7'(ay0); w = 8'(aw); h = 7'(ah);
        colour_in = 3'(acol); start = 1'b1;
        @(posedge clock); #1;
        n0 = cyc;
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        clear = 1'($urandom); x0 = 8'($urandom); y0 = 7'($urandom);
        w = 8'($urandom); h = 7'($urandom); colour_in = 3'($urandom);
        if (poke) begin
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clock);
                if (got_q.size() > 0) seen = 1;
            end
            check({nm, "_poke_window"}, int'(seen), 1);
            clear = 1'b0; x0 = 8'd50; y0 = 7'd50; w = 8'd3; h = 7'd3; start = 1'b1;
            repeat (3) @(negedge clock);
            start = 1'b0;
        end
        for (int i = 0; i < exp_q.size() + 100 && done_cnt == 0; i++) @(negedge clock);
        repeat (6) @(negedge clock);
        check({nm, "_count"}, got_q.size(), exp_q.size());
        mism = 0;
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++) if (got_q[i] !== exp_q[i]) mism++;
        check({nm, "_pixels"}, mism, 0);
        check({nm, "_done_cnt"}, done_cnt, 1);
        if (exp_q.size() > 0) begin
            check({nm, "_first_lat"}, first_cyc - n0, 2);
            check({nm, "_gapless"}, last_cyc - first_cyc + 1, exp_q.size());
            check({nm, "_done_after_last"}, done_cyc - last_cyc, 1);
        end else begin
            check({nm, "_done_lat"}, done_cyc - n0, 2);
        end
        check({nm, "_idle_busy"}, int'(busy), 0);
    endtask

    vec_t vecs[11];

    initial begin
        int  ax0, ay0, aw, ah;
        bit  seen;
        vecs[0]  = '{1'b0, 10, 5, 3, 2, 3'b100, 6, 10, 5, 12, 6};
        vecs[1]  = '{1'b0, 158, 118, 5, 5, 3'b001, 4, 158, 118, 159, 119};
        vecs[2]  = '{1'b0, 10, 10, 0, 4, 3'b011, 0, 0, 0, 0, 0};
        vecs[3]  = '{1'b0, 200, 5, 4, 4, 3'b011, 0, 0, 0, 0, 0};
        vecs[4]  = '{1'b0, 20, 20, 4, 0, 3'b011, 0, 0, 0, 0, 0};
        vecs[5]  = '{1'b0, 20, 120, 4, 4, 3'b011, 0, 0, 0, 0, 0};
        vecs[6]  = '{1'b0, 159, 119, 1, 1, 3'b111, 1, 159, 119, 159, 119};
        vecs[7]  = '{1'b0, 0, 0, 255, 1, 3'b101, 160, 0, 0, 159, 0};
        vecs[8]  = '{1'b0, 0, 100, 1, 127, 3'b110, 20, 0, 100, 0, 119};
        vecs[9]  = '{1'b1, 200, 3, 0, 0, 3'b010, 19200, 0, 0, 159, 119};
        vecs[10] = '{1'b0, 255, 127, 255, 127, 3'b001, 0, 0, 0, 0, 0};

        #1;
        check("reset_outputs", int'({x, y, colour, plot, busy, done}), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_outputs", int'({plot, busy, done}), 0);

        for (int i = 0; i < 11; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].clr, vecs[i].vx0, vecs[i].vy0,
                    vecs[i].vw, vecs[i].vh, vecs[i].vcol, 1'b0);
            check($sformatf("vec%0d_tbl_n", i), got_q.size(), vecs[i].n);
            if (vecs[i].n > 0 && got_q.size() > 0) begin
                check($sformatf("vec%0d_first", i), int'({got_q[0].px, got_q[0].py}),
                      int'({8'(vecs[i].fx), 7'(vecs[i].fy)}));
                check($sformatf("vec%0d_last", i),
                      int'({got_q[got_q.size()-1].px, got_q[got_q.size()-1].py}),
                      int'({8'(vecs[i].lx), 7'(vecs[i].ly)}));
                check($sformatf("vec%0d_colour", i), int'(got_q[0].pc), vecs[i].vcol);
            end
        end

        run_req("busy_ignore", 1'b0, 40, 40, 4, 4, 3'b110, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ax0 = $urandom_range(0, 175);
            ay0 = $urandom_range(0, 127);
            if (i % 4 == 0) begin
                ax0 = $urandom_range(150, 165);
                ay0 = $urandom_range(110, 125);
            end
            aw = $urandom_range(0, 12);
            ah = $urandom_range(0, 6);
            run_req($sformatf("rnd%0d", i), 1'b0, ax0, ay0, aw, ah, $urandom_range(0, 7), 1'b0);
        end

        @(negedge clock); #1;
        got_q.delete(); done_cnt = 0; first_cyc = -1;
        clear = 1'b0; x0 = 8'd20; y0 = 7'd20; w = 8'd4; h = 7'd4; colour_in = 3'b111;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (got_q.size() >= 5) seen = 1;
        end
        check("rst_five_plots", int'(seen), 1);
        #2 resetn = 1'b0;
        #1;
        check("rst_outputs_zero", int'({x, y, colour, plot, busy, done}), 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        check("rst_no_done", done_cnt, 0);
        check("rst_partial_fill", int'(got_q.size() < 16), 1);
        run_req("rst_then_1x1", 1'b0, 30, 30, 1, 1, 3'b101, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
